mvm_acc_q: RTL

Parametrised fixed-point matrix-vector multiplier computing y = A·x for a DIM×DIM signed matrix and DIM-element vector in Q(BIT_NUM, FRAC_NUM) format. It streams one matrix column and one vector element per accepted beat, accumulates at full precision, and quantizes once per vector with selectable saturate or wrap. It sits in the datapath where the fixed 2×2·2×1 multiply stage was used and generalises it to DIM lanes with valid/ready flow control, overflow reporting and flush.

---
 rtl/mvm_acc_q_if.sv | 28 ++
 rtl/mvm_acc_q.sv | 117 +++++++++++
 2 files changed

// File: rtl/mvm_acc_q_if.sv
// Beat/result handshake bundle for the mvm_acc_q matrix-vector multiplier.
// Master drives columns, vector elements and result ready; slave returns results.
// Backpressure: in_ready/out_ready valid-ready pairs on both directions.
interface mvm_acc_q_if #(
    parameter int BIT_NUM = 18,
    parameter int DIM     = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [DIM*BIT_NUM-1:0]   a_col;
    logic [BIT_NUM-1:0]       x_elem;
    logic                     flush;
    logic                     sat_en;
    logic                     out_valid;
    logic                     out_ready;
    logic [DIM*BIT_NUM-1:0]   y_vec;
    logic                     out_ovf;

    modport master (
        output in_valid, a_col, x_elem, flush, sat_en, out_ready,
        input  in_ready, out_valid, y_vec, out_ovf
    );

    modport slave (
        input  in_valid, a_col, x_elem, flush, sat_en, out_ready,
        output in_ready, out_valid, y_vec, out_ovf
    );
endinterface

// File: rtl/mvm_acc_q.sv
// Fixed-point y = A*x, one column of A and one x element per beat, toward-zero quantized.
// Latency: result registered the cycle after the final beat; one vector per DIM beats.
// Backpressure: non-final beats always flow; only the final beat waits for the output slot.
module mvm_acc_q #(
    parameter int BIT_NUM  = 18,
    parameter int FRAC_NUM = 9,
    parameter int DIM      = 4
) (
    input  logic        clk,
    input  logic        srst_n,
    mvm_acc_q_if.slave  bus
);
    localparam int CNT_W = $clog2(DIM);
    localparam int ACC_W = 2*BIT_NUM + $clog2(DIM);
    localparam int EXT_W = ACC_W - 2*BIT_NUM;
    localparam logic signed [ACC_W-1:0] Q_MAX =
        {{(ACC_W-BIT_NUM+1){1'b0}}, {(BIT_NUM-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] Q_MIN =
        {{(ACC_W-BIT_NUM+1){1'b1}}, {(BIT_NUM-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIM-1);

    logic [1:0]               rst_sync;
    logic                     rst_n_i;
    logic [CNT_W-1:0]         cnt;
    logic signed [ACC_W-1:0]  acc      [DIM];
    logic signed [ACC_W-1:0]  lane_sum [DIM];
    logic [DIM*BIT_NUM-1:0]   y_nxt;
    logic [DIM-1:0]           lane_ovf;
    logic                     last_beat;
    logic                     first_beat;
    logic                     beat_acc;
    logic                     out_take;

    // Reset asserts immediately but releases on a clock edge to keep recovery timing clean.
    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n_i    = rst_sync[1];
    assign last_beat  = (cnt == CNT_LAST);
    assign first_beat = (cnt == '0);
    assign bus.in_ready = rst_n_i & ~bus.flush
                        & (~last_beat | ~bus.out_valid | bus.out_ready);
    assign beat_acc   = bus.in_valid & bus.in_ready;
    assign out_take   = bus.out_valid & bus.out_ready;

    for (genvar g = 0; g < DIM; g++) begin : g_lane
        logic signed [BIT_NUM-1:0]   a_l;
        logic signed [BIT_NUM-1:0]   x_s;
        logic signed [2*BIT_NUM-1:0] prod;
        logic signed [ACC_W-1:0]     prod_ext;
        logic signed [ACC_W-1:0]     base;
        logic signed [ACC_W-1:0]     shr;
        logic signed [ACC_W-1:0]     rq;
        logic                        frac_nz;
        logic                        hi;
        logic                        lo;

        assign a_l      = bus.a_col[g*BIT_NUM +: BIT_NUM];
        assign x_s      = bus.x_elem;
        assign prod     = a_l * x_s;
        assign prod_ext = {{EXT_W{prod[2*BIT_NUM-1]}}, prod};
        // Column 0 starts a fresh sum, so stale accumulator contents never leak in.
        assign base     = first_beat ? '0 : acc[g];
        assign lane_sum[g] = base + prod_ext;

        // Floor shift, then bump negatives with a non-zero fraction to round toward zero.
        assign shr      = lane_sum[g] >>> FRAC_NUM;
        assign frac_nz  = |lane_sum[g][FRAC_NUM-1:0];
        assign rq       = shr + ACC_W'(lane_sum[g][ACC_W-1] & frac_nz);
        assign hi       = (rq > Q_MAX);
        assign lo       = (rq < Q_MIN);
        assign lane_ovf[g] = hi | lo;

        assign y_nxt[g*BIT_NUM +: BIT_NUM] =
            (bus.sat_en && hi) ? Q_MAX[BIT_NUM-1:0] :
            (bus.sat_en && lo) ? Q_MIN[BIT_NUM-1:0] :
                                 rq[BIT_NUM-1:0];
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt           <= '0;
            bus.out_valid <= 1'b0;
            bus.y_vec     <= '0;
            bus.out_ovf   <= 1'b0;
            for (int i = 0; i < DIM; i++) begin
                acc[i] <= '0;
            end
        end else begin
            if (bus.flush) begin
                cnt <= '0;
            end else if (beat_acc) begin
                cnt <= last_beat ? '0 : cnt + CNT_W'(1);
            end

            if (beat_acc) begin
                for (int i = 0; i < DIM; i++) begin
                    acc[i] <= lane_sum[i];
                end
            end

            // Final beat is only accepted when the slot is free or draining, so no overwrite.
            if (beat_acc && last_beat) begin
                bus.out_valid <= 1'b1;
                bus.y_vec     <= y_nxt;
                bus.out_ovf   <= |lane_ovf;
            end else if (out_take) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule
